// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a length-prefixed byte stream into 16-bit
// words, writes them at consecutive addresses and verifies a trailing XOR checksum.
module imem_loader #(
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       idx_q, idx_d;
    logic [7:0]        hi_q, hi_d;
    logic [7:0]        chk_q, chk_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic        xfer;
    logic        start_ok;
    logic [15:0] len_full;
    logic        len_over;
    logic [7:0]  chk_next;
    logic [15:0] idx_inc;

    assign xfer     = byte_valid & byte_ready;
    assign start_ok = start & ((state_q == S_IDLE) | (state_q == S_DONE) | (state_q == S_ERR));
    assign len_full = {len_hi_q, byte_data};
    assign len_over = 32'(len_full) > DEPTH;
    assign chk_next = chk_q ^ byte_data;
    assign idx_inc  = idx_q + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            len_hi_q <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            hi_q     <= '0;
            chk_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            hold_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_hi_q <= len_hi_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            hi_q     <= hi_d;
            chk_q    <= chk_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            hold_q   <= hold_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: if (start_ok) state_d = S_LEN_HI;
            S_LEN_HI:  if (xfer) state_d = S_LEN_LO;
            S_LEN_LO: begin
                if (xfer) begin
                    if (len_full == 16'd0) state_d = S_CHECK;
                    else if (len_over)     state_d = S_ERR;
                    else                   state_d = S_DATA_HI;
                end
            end
            S_DATA_HI: if (xfer) state_d = S_DATA_LO;
            S_DATA_LO: if (xfer) state_d = (idx_inc == len_q) ? S_CHECK : S_DATA_HI;
            S_CHECK:   if (xfer) state_d = (chk_next == 8'd0) ? S_DONE : S_ERR;
            default:   state_d = S_IDLE;
        endcase
    end

    // Datapath and status registers; the memory write lands one cycle after the LO byte.
    always_comb begin
        byte_ready = (state_q == S_LEN_HI) | (state_q == S_LEN_LO) | (state_q == S_DATA_HI)
                   | (state_q == S_DATA_LO) | (state_q == S_CHECK);
        len_hi_d = len_hi_q;
        len_d    = len_q;
        idx_d    = idx_q;
        hi_d     = hi_q;
        chk_d    = chk_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        hold_d   = hold_q;
        done_d   = done_q;
        err_d    = err_q;
        if (start_ok) begin
            hold_d = 1'b1;
            done_d = 1'b0;
            err_d  = 1'b0;
            chk_d  = '0;
            idx_d  = '0;
        end
        if (xfer) begin
            chk_d = chk_next;
            case (state_q)
                S_LEN_HI: len_hi_d = byte_data;
                S_LEN_LO: begin
                    len_d = len_full;
                    if (len_full != 16'd0 && len_over) begin
                        err_d  = 1'b1;
                        hold_d = 1'b0;
                    end
                end
                S_DATA_HI: hi_d = byte_data;
                S_DATA_LO: begin
                    we_d    = 1'b1;
                    addr_d  = BASE_ADDR + idx_q[ADDR_W-1:0];
                    wdata_d = {hi_q, byte_data};
                    idx_d   = idx_inc;
                end
                S_CHECK: begin
                    hold_d = 1'b0;
                    done_d = (chk_next == 8'd0);
                    err_d  = (chk_next != 8'd0);
                end
                default: ;
            endcase
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_hold   = hold_q;
    assign done       = done_q;
    assign error      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: two instances (base 0 and base 1022) share one stream.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;

    logic       ready_a, we_a, hold_a, done_a, err_a;
    logic [9:0] addr_a;
    logic [15:0] wdata_a;
    logic       ready_b, we_b, hold_b, done_b, err_b;
    logic [9:0] addr_b;
    logic [15:0] wdata_b;

    int checks = 0;
    int failures = 0;

    logic [25:0] wr_a[$];
    logic [25:0] wr_b[$];
    logic [7:0]  byte_q[$];

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(10), .BASE_ADDR(10'd0)) dut_a (
        .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(ready_a), .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wdata_a),
        .cpu_hold(hold_a), .done(done_a), .error(err_a));

    imem_loader #(.ADDR_W(10), .BASE_ADDR(10'd1022)) dut_b (
        .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(ready_b), .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b),
        .cpu_hold(hold_b), .done(done_b), .error(err_b));

    always @(negedge clk) begin
        if (we_a) wr_a.push_back({addr_a, wdata_a});
        if (we_b) wr_b.push_back({addr_b, wdata_b});
    end

    typedef struct {
        logic [15:0]      n;
        logic [2:0][15:0] w;
        logic [7:0]       chk;
        bit               gaps;
        bit               exp_done;
        int               nwr;
    } load_vec_t;

    load_vec_t vecs[7];

    function automatic load_vec_t mk(logic [15:0] n, logic [15:0] w0, logic [15:0] w1,
                                     logic [15:0] w2, logic [7:0] c, bit g, bit d, int nw);
        load_vec_t v;
        v.n = n; v.w = {w2, w1, w0}; v.chk = c; v.gaps = g; v.exp_done = d; v.nwr = nw;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {ready_a, ready_b}, 2'b00);
        check({tag, "_we"},    {we_a, we_b}, 2'b00);
        check({tag, "_addr"},  {addr_a, addr_b}, 20'h0);
        check({tag, "_wdata"}, {wdata_a, wdata_b}, 32'h0);
        check({tag, "_hold"},  {hold_a, hold_b}, 2'b00);
        check({tag, "_status"}, {done_a, err_a, done_b, err_b}, 4'b0000);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("start_status", {hold_a, done_a, err_a, ready_a, hold_b}, 5'b10011);
    endtask

    // Sends byte_q; with gaps, byte_valid alternates 1,0,1,0. Ends on the negedge after the last transfer.
    task automatic send_stream(input bit gaps, output bit ready_ok);
        int  i = 0;
        int  cyc = 0;
        bit  tog = 1'b1;
        bit  rdy;
        ready_ok = 1'b1;
        while (i < byte_q.size() && cyc < 2000) begin
            rdy = ready_a;
            if (!rdy || !ready_b) ready_ok = 1'b0;
            byte_valid = gaps ? tog : 1'b1;
            tog = ~tog;
            byte_data = byte_q[i];
            @(posedge clk);
            if (byte_valid && rdy) i++;
            cyc++;
            @(negedge clk);
        end
        byte_valid = 1'b0;
        check("stream_timeout", (cyc >= 2000) ? 32'd1 : 32'd0, 32'd0);
    endtask

    task automatic run_case(input int id, input load_vec_t v);
        bit ready_ok;
        logic [9:0] ea, eb;
        wr_a.delete();
        wr_b.delete();
        do_start();
        byte_q.delete();
        byte_q.push_back(v.n[15:8]);
        byte_q.push_back(v.n[7:0]);
        if (v.n <= 16'd1024) begin
            for (int k = 0; k < int'(v.n); k++) begin
                byte_q.push_back(v.w[k][15:8]);
                byte_q.push_back(v.w[k][7:0]);
            end
            byte_q.push_back(v.chk);
        end
        send_stream(v.gaps, ready_ok);
        check($sformatf("c%0d_ready_during_load", id), {31'd0, ready_ok}, 32'd1);
        check($sformatf("c%0d_final_a", id), {done_a, err_a, hold_a, ready_a},
              {v.exp_done, ~v.exp_done, 1'b0, 1'b0});
        check($sformatf("c%0d_final_b", id), {done_b, err_b, hold_b, ready_b},
              {v.exp_done, ~v.exp_done, 1'b0, 1'b0});
        check($sformatf("c%0d_nwr_a", id), wr_a.size(), v.nwr);
        check($sformatf("c%0d_nwr_b", id), wr_b.size(), v.nwr);
        for (int k = 0; k < v.nwr && k < wr_a.size() && k < wr_b.size(); k++) begin
            ea = 10'(k);
            eb = 10'((1022 + k) % 1024);
            check($sformatf("c%0d_wr%0d_a", id, k), wr_a[k], {ea, v.w[k]});
            check($sformatf("c%0d_wr%0d_b", id, k), wr_b[k], {eb, v.w[k]});
        end
    endtask

    initial begin
        bit rdy_ok;
        vecs[0] = mk(16'd2, 16'h1234, 16'hABCD, 16'h0000, 8'h42, 1'b0, 1'b1, 2);
        vecs[1] = mk(16'd2, 16'h1234, 16'hABCD, 16'h0000, 8'h42, 1'b1, 1'b1, 2);
        vecs[2] = mk(16'd0, 16'h0000, 16'h0000, 16'h0000, 8'h00, 1'b0, 1'b1, 0);
        vecs[3] = mk(16'd0, 16'h0000, 16'h0000, 16'h0000, 8'h01, 1'b0, 1'b0, 0);
        vecs[4] = mk(16'h0401, 16'h0000, 16'h0000, 16'h0000, 8'h00, 1'b0, 1'b0, 0);
        vecs[5] = mk(16'd3, 16'h1111, 16'h2222, 16'h3333, 8'h03, 1'b0, 1'b1, 3);
        vecs[6] = mk(16'd3, 16'h1111, 16'h2222, 16'h3333, 8'h04, 1'b1, 1'b0, 3);

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_case(i, vecs[i]);
            $display("case %0d n=%h done=%b error=%b writes=%0d", i, vecs[i].n, done_a, err_a, wr_a.size());
        end

        // Reset mid-load after the HI byte of the second word.
        wr_a.delete();
        wr_b.delete();
        do_start();
        byte_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
        send_stream(1'b0, rdy_ok);
        check("midrst_first_write", wr_a.size(), 1);
        wr_a.delete();
        wr_b.delete();
        byte_valid = 1'b1;
        byte_data  = 8'hCD;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        byte_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_no_write", wr_a.size() + wr_b.size(), 0);
        $display("midload reset writes_after=%0d", wr_a.size());
        run_case(7, vecs[0]);
        $display("reload after reset done=%b writes=%0d", done_a, wr_a.size());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
